// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with branch redirect and drain of stale reads
// Ports: clk/rst (sync, active-high); pc_plus_one in, pc_write/pc_data out (PC load);
// mem_req/mem_addr out, mem_ack/mem_rdata in (instruction memory);
// branch_taken/branch_target in (redirect); instr/instr_pc/instr_valid out, instr_ready in (decode).
module fetch_unit #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_plus_one,
    output logic        pc_write,
    output logic [15:0] pc_data,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
    state_t state_q, state_d;
    logic [15:0] fetch_addr_q, fetch_addr_d, drain_addr_q, drain_addr_d;
    logic [15:0] instr_q, instr_d, instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    // DRAIN keeps presenting the abandoned address so the request stays stable until its ack
    assign mem_req     = state_q != HOLD;
    assign mem_addr    = state_q == DRAIN ? drain_addr_q : fetch_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        drain_addr_d  = drain_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pc_write      = 1'b0;
        pc_data       = pc_plus_one;
        if (branch_taken) begin
            pc_write      = 1'b1;
            pc_data       = branch_target;
            fetch_addr_d  = branch_target;
            instr_valid_d = 1'b0;
            state_d       = (state_q == HOLD || mem_ack) ? FETCH : DRAIN;
            // a redirect already in DRAIN keeps the original stale address
            if (state_q == FETCH) drain_addr_d = fetch_addr_q;
        end else if (state_q == FETCH && mem_ack) begin
            pc_write      = 1'b1;
            instr_d       = mem_rdata;
            instr_pc_d    = fetch_addr_q;
            instr_valid_d = 1'b1;
            fetch_addr_d  = pc_plus_one;
            state_d       = HOLD;
        end else if (state_q == HOLD && instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = FETCH;
        end else if (state_q == DRAIN && mem_ack) begin
            state_d = FETCH;
        end
        if (rst) pc_write = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_addr_q  <= RESET_ADDR;
            drain_addr_q  <= RESET_ADDR;
            instr_q       <= 16'h0000;
            instr_pc_q    <= 16'h0000;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            drain_addr_q  <= drain_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a program-order stream model
module tb_fetch_unit;
    localparam logic [15:0] RA = 16'h0000;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_plus_one;
    logic        pc_write;
    logic [15:0] pc_data;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] pc_q;
    logic [15:0] exp_q[$];
    logic [15:0] tail;
    int          checks = 0;
    int          failures = 0;
    int          transfers = 0;
    logic        prev_pend = 1'b0;
    logic [15:0] prev_addr = 16'h0000;

    fetch_unit #(.RESET_ADDR(RA)) dut (
        .clk(clk), .rst(rst), .pc_plus_one(pc_plus_one), .pc_write(pc_write), .pc_data(pc_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .branch_taken(branch_taken), .branch_target(branch_target), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    // memory content is a pure function of the address; the PC is an external register
    assign mem_rdata   = word_at(mem_addr);
    assign pc_plus_one = pc_q + 16'h0001;
    always @(posedge clk) pc_q <= rst ? RA : (pc_write ? pc_data : pc_q);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic restart(input logic [15:0] a);
        exp_q.delete();
        tail = a;
    endtask

    task automatic top_up;
        while (exp_q.size() < 4) begin
            exp_q.push_back(tail);
            tail = tail + 16'h0001;
        end
    endtask

    // monitor: samples on the falling edge, pops the expected stream on every accepted transfer
    always @(negedge clk) begin
        if (rst) begin
            chk("pc_write_in_reset", {15'd0, pc_write}, 16'd0);
        end else begin
            if (prev_pend) begin
                chk("req_held", {15'd0, mem_req}, 16'd1);
                chk("addr_held", mem_addr, prev_addr);
            end
            if (branch_taken) begin
                chk("branch_pc_write", {15'd0, pc_write}, 16'd1);
                chk("branch_pc_data", pc_data, branch_target);
            end else if (pc_write) begin
                chk("pc_write_needs_ack", {15'd0, mem_ack}, 16'd1);
            end
            if (instr_valid) begin
                chk("no_req_while_held", {15'd0, mem_req}, 16'd0);
                if (instr_ready && !branch_taken) begin
                    transfers++;
                    if (exp_q.size() == 0) begin
                        chk("stream_underflow", instr_pc, 16'hxxxx);
                    end else begin
                        chk("instr_pc", instr_pc, exp_q[0]);
                        chk("instr", instr, word_at(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
        prev_pend = !rst && mem_req && !mem_ack;
        prev_addr = mem_addr;
    end

    initial begin
        logic [15:0] t;
        tail = RA;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        restart(RA);
        top_up();
        @(negedge clk);
        chk("reset_valid", {15'd0, instr_valid}, 16'd0);
        chk("reset_instr", instr, 16'h0000);
        chk("reset_instr_pc", instr_pc, 16'h0000);
        chk("reset_mem_req", {15'd0, mem_req}, 16'd1);
        chk("reset_mem_addr", mem_addr, RA);
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom % 150) == 0;
            branch_taken = !rst && ($urandom % 8) == 0;
            case ($urandom % 4)
                0: t = 16'hFFFE;
                1: t = 16'hFFFF;
                default: t = 16'($urandom);
            endcase
            branch_target = t;
            instr_ready = ($urandom % 3) != 0;
            mem_ack = ($urandom % 2) == 0;
            if (rst) restart(RA);
            else if (branch_taken) restart(t);
            top_up();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        checks++;
        if (transfers < 300) begin
            failures++;
            $display("FAIL progress actual=%0d required>=300", transfers);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
